mmio_bus_fabric: RTL and testbench

Parametrised CPU-to-core memory bus fabric for the application FPGA, the next generation of the top-level address decoder. Decodes the PicoRV32 native memory bus onto up to NUM_CORES core ports by 8-bit address prefix and registers the response. Adds what the fixed decoder lacks:
- a per-access ready timeout;
- error responses for unmapped or timed-out accesses;
- a sticky error capture readable by firmware via the TK1 core.

---
 rtl/mmio_bus_fabric.sv | 197 +++++++++++++++++++
 tb/tb_mmio_bus_fabric.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_fabric.sv
// CPU-to-core MMIO fabric: decodes the PicoRV32 native bus onto core ports by address prefix,
// with per-access ready timeout, error responses and a sticky error capture.
module mmio_bus_fabric #(
    parameter int                     NUM_CORES      = 8,
    parameter logic [NUM_CORES*8-1:0] CORE_PREFIXES  = 64'h3f10050403020100,
    parameter int                     ADDR_BITS      = 8,
    parameter int                     TIMEOUT_CYCLES = 255,
    parameter logic [31:0]            ERR_RDATA      = 32'hdeadbeef
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_valid,
    input  logic [31:0]             cpu_addr,
    input  logic [3:0]              cpu_wstrb,
    input  logic [31:0]             cpu_wdata,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_ready,
    output logic [NUM_CORES-1:0]    core_cs,
    output logic                    core_we,
    output logic [3:0]              core_wstrb,
    output logic [ADDR_BITS-1:0]    core_address,
    output logic [31:0]             core_write_data,
    input  logic [NUM_CORES*32-1:0] core_read_data,
    input  logic [NUM_CORES-1:0]    core_ready,
    input  logic                    err_clear,
    output logic                    err_valid,
    output logic [1:0]              err_cause,
    output logic [31:0]             err_addr,
    output logic [7:0]              err_count
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_cause_q, err_cause_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic [7:0]        err_count_q, err_count_d;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              err_flag;
    logic [1:0]        err_cause_new;
    logic [31:0]       err_addr_new;
    logic              ev_base;
    logic [1:0]        cause_base;
    logic [31:0]       eaddr_base;
    logic [7:0]        count_base;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (cpu_addr[31:24] == CORE_PREFIXES[8*i +: 8]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wstrb_d       = wstrb_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        ready_d       = 1'b0;
        err_flag      = 1'b0;
        err_cause_new = 2'b00;
        err_addr_new  = 32'h0;
        case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    addr_d  = cpu_addr;
                    wstrb_d = cpu_wstrb;
                    wdata_d = cpu_wdata;
                    if (hit) begin
                        idx_d   = hit_idx;
                        cnt_d   = 16'h0;
                        state_d = ACCESS;
                    end else begin
                        rdata_d       = ERR_RDATA;
                        err_flag      = 1'b1;
                        err_cause_new = 2'b01;
                        err_addr_new  = cpu_addr;
                        state_d       = RESP;
                    end
                end
            end
            ACCESS: begin
                // Ready is checked before the limit so a last-cycle ready still completes normally.
                if (core_ready[idx_q]) begin
                    rdata_d = core_read_data[idx_q*32 +: 32];
                    state_d = RESP;
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d       = ERR_RDATA;
                    err_flag      = 1'b1;
                    err_cause_new = 2'b10;
                    err_addr_new  = addr_q;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A clear in the same cycle as a new error still captures that error.
    always_comb begin
        ev_base     = err_clear ? 1'b0  : err_valid_q;
        cause_base  = err_clear ? 2'b00 : err_cause_q;
        eaddr_base  = err_clear ? 32'h0 : err_addr_q;
        count_base  = err_clear ? 8'h00 : err_count_q;
        err_valid_d = ev_base;
        err_cause_d = cause_base;
        err_addr_d  = eaddr_base;
        err_count_d = count_base;
        if (err_flag) begin
            if (!ev_base) begin
                err_valid_d = 1'b1;
                err_cause_d = err_cause_new;
                err_addr_d  = err_addr_new;
            end
            err_count_d = (count_base == 8'hff) ? 8'hff : count_base + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= 16'h0;
            addr_q      <= 32'h0;
            wstrb_q     <= 4'h0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            ready_q     <= 1'b0;
            err_valid_q <= 1'b0;
            err_cause_q <= 2'b00;
            err_addr_q  <= 32'h0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_valid_q <= err_valid_d;
            err_cause_q <= err_cause_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        core_cs = '0;
        if (state_q == ACCESS) begin
            core_cs[idx_q] = 1'b1;
        end
    end

    assign cpu_rdata       = rdata_q;
    assign cpu_ready       = ready_q;
    assign core_we         = |wstrb_q;
    assign core_wstrb      = wstrb_q;
    assign core_address    = addr_q[ADDR_BITS+1:2];
    assign core_write_data = wdata_q;
    assign err_valid       = err_valid_q;
    assign err_cause       = err_cause_q;
    assign err_addr        = err_addr_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed bench for mmio_bus_fabric: transaction-level model of latency, chip select,
// response data and error capture, checked every cycle, plus literal pins.
module tb_mmio_bus_fabric;

    localparam int          T   = 4;
    localparam logic [63:0] PFX = 64'h3f1005040302c100;
    localparam logic [31:0] ERR = 32'hdeadbeef;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_valid;
    logic [31:0]  cpu_addr;
    logic [3:0]   cpu_wstrb;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic [7:0]   core_cs;
    logic         core_we;
    logic [3:0]   core_wstrb;
    logic [7:0]   core_address;
    logic [31:0]  core_write_data;
    logic [255:0] core_read_data;
    logic [7:0]   core_ready;
    logic         err_clear;
    logic         err_valid;
    logic [1:0]   err_cause;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    mmio_bus_fabric #(
        .NUM_CORES(8), .CORE_PREFIXES(PFX), .ADDR_BITS(8),
        .TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)
    ) dut (
        .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
        .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .core_cs(core_cs), .core_we(core_we),
        .core_wstrb(core_wstrb), .core_address(core_address),
        .core_write_data(core_write_data), .core_read_data(core_read_data),
        .core_ready(core_ready), .err_clear(err_clear), .err_valid(err_valid),
        .err_cause(err_cause), .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Core behaviour: wait cycles before ready (>= T means never) and read data.
    function automatic int wait_of(input int i);
        case (i)
            7: return 0;
            1: return 0;
            2: return 2;
            3: return T - 1;
            4: return 100;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] data_of(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 7) return 32'h12345678;
        return {8'hc0 + b, 24'h00beef};
    endfunction

    function automatic int lookup(input logic [31:0] a);
        logic [63:0] p;
        p = PFX;
        for (int i = 0; i < 8; i++) if (p[8*i +: 8] == a[31:24]) return i;
        return -1;
    endfunction

    int         cs_run = 0;
    logic [7:0] noise  = 8'h00;

    always @(posedge clk) cs_run <= (core_cs != 8'h00) ? cs_run + 1 : 0;

    always_comb begin
        core_ready = noise & ~core_cs;
        for (int i = 0; i < 8; i++) begin
            core_read_data[32*i +: 32] = data_of(i);
            if (core_cs[i] && cs_run >= wait_of(i)) core_ready[i] = 1'b1;
        end
    end

    // Model state: current transaction and the error capture.
    int          cyc        = 0;
    int          m_k        = 0;
    int          m_idx      = -1;
    int          m_ncs      = 0;
    int          m_ready_at = -1;
    int          m_err_at   = -1;
    logic [31:0] m_rdata    = 32'h0;
    logic [1:0]  m_new_cause = 2'b00;
    logic [31:0] m_new_addr = 32'h0;
    logic [31:0] m_a        = 32'h0;
    logic [3:0]  m_ws       = 4'h0;
    logic [31:0] m_wd       = 32'h0;
    logic        m_ev       = 1'b0;
    logic [1:0]  m_cause    = 2'b00;
    logic [31:0] m_eaddr    = 32'h0;
    int          m_count    = 0;

    always @(posedge clk) begin
        logic [7:0] exp_cs;
        cyc = cyc + 1;
        #1;
        if (reset) begin
            m_idx = -1; m_ready_at = -1; m_err_at = -1;
            m_ev = 1'b0; m_cause = 2'b00; m_eaddr = 32'h0; m_count = 0;
        end else begin
            if (err_clear) begin
                m_ev = 1'b0; m_cause = 2'b00; m_eaddr = 32'h0; m_count = 0;
            end
            if (cyc == m_err_at) begin
                if (!m_ev) begin
                    m_ev = 1'b1; m_cause = m_new_cause; m_eaddr = m_new_addr;
                end
                if (m_count < 255) m_count = m_count + 1;
            end
        end
        exp_cs = (m_idx >= 0 && cyc >= m_k && cyc < m_k + m_ncs) ? (8'b1 << m_idx) : 8'h00;
        chk("core_cs", {24'h0, core_cs}, {24'h0, exp_cs});
        chk("cpu_ready", {31'h0, cpu_ready}, {31'h0, cyc == m_ready_at});
        if (cpu_ready) chk("cpu_rdata", cpu_rdata, m_rdata);
        chk("err_valid", {31'h0, err_valid}, {31'h0, m_ev});
        chk("err_cause", {30'h0, err_cause}, {30'h0, m_cause});
        chk("err_addr", err_addr, m_eaddr);
        chk("err_count", {24'h0, err_count}, 32'(m_count));
        if (exp_cs != 8'h00) begin
            chk("core_address", {24'h0, core_address}, {24'h0, m_a[9:2]});
            chk("core_we", {31'h0, core_we}, {31'h0, |m_ws});
            chk("core_wstrb", {28'h0, core_wstrb}, {28'h0, m_ws});
            chk("core_write_data", core_write_data, m_wd);
        end
        if (reset) begin
            chk("rst_rdata", cpu_rdata, 32'h0);
            chk("rst_core_addr", {24'h0, core_address}, 32'h0);
            chk("rst_core_we", {31'h0, core_we}, 32'h0);
            chk("rst_core_wdata", core_write_data, 32'h0);
        end
    end

    task automatic do_access(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                             input int abort_after, input bit drop_early, input bit clr,
                             output int lat, output logic [31:0] rd);
        int  idx, w, k;
        bit  done;
        @(negedge clk);
        idx = lookup(a);
        k   = cyc + 1;
        m_k = k; m_a = a; m_ws = ws; m_wd = wd;
        if (idx < 0) begin
            m_idx = -1; m_ncs = 0; m_ready_at = k + 1; m_rdata = ERR;
            m_err_at = k; m_new_cause = 2'b01; m_new_addr = a;
        end else begin
            w = wait_of(idx);
            m_idx = idx;
            m_ncs = (w >= T) ? T : w + 1;
            m_ready_at = k + m_ncs + 1;
            m_rdata = (w >= T) ? ERR : data_of(idx);
            m_err_at = (w >= T) ? k + T : -1;
            m_new_cause = 2'b10; m_new_addr = a;
        end
        cpu_valid = 1'b1; cpu_addr = a; cpu_wstrb = ws; cpu_wdata = wd; err_clear = clr;
        lat = -1; rd = 32'h0; done = 1'b0;
        if (abort_after > 0) begin
            repeat (abort_after) @(negedge clk);
            cpu_valid = 1'b0; err_clear = 1'b0; reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge clk);
            if (n == 1) begin
                err_clear = 1'b0;
                if (drop_early) cpu_valid = 1'b0;
            end
            if (cpu_ready) begin
                lat = n - 1; rd = cpu_rdata; done = 1'b1;
            end
        end
        chk("ready_within_bound", {31'h0, done}, 32'h1);
        cpu_valid = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        reset = 1'b1; cpu_valid = 1'b0; cpu_addr = 32'h0; cpu_wstrb = 4'h0;
        cpu_wdata = 32'h0; err_clear = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        do_access(32'h3f000020, 4'h0, 32'h0, 0, 1'b0, 1'b0, lat, rd);
        chk("rd7_latency", lat, 32'd2);
        chk("rd7_data", rd, 32'h12345678);
        chk("rd7_err_valid", {31'h0, err_valid}, 32'h0);

        do_access(32'hc1000010, 4'b1111, 32'hcafef00d, 0, 1'b0, 1'b0, lat, rd);
        chk("wr1_latency", lat, 32'd2);
        chk("wr1_core_address", {24'h0, core_address}, 32'h04);
        chk("wr1_core_we", {31'h0, core_we}, 32'h1);

        do_access(32'h80000000, 4'h0, 32'h0, 0, 1'b0, 1'b0, lat, rd);
        chk("unm_latency", lat, 32'd1);
        chk("unm_rdata", rd, 32'hdeadbeef);
        chk("unm_cause", {30'h0, err_cause}, 32'h1);
        chk("unm_addr", err_addr, 32'h80000000);
        chk("unm_count", {24'h0, err_count}, 32'h1);

        noise = 8'h80;
        do_access(32'h02000008, 4'h0, 32'h0, 0, 1'b1, 1'b0, lat, rd);
        noise = 8'h00;
        chk("wait2_latency", lat, 32'd4);

        do_access(32'h03000004, 4'h0, 32'h0, 0, 1'b0, 1'b0, lat, rd);
        chk("lastcycle_latency", lat, 32'd5);
        chk("lastcycle_count", {24'h0, err_count}, 32'h1);

        do_access(32'h04000000, 4'b0011, 32'h0badf00d, 0, 1'b0, 1'b0, lat, rd);
        chk("tmo_latency", lat, 32'd5);
        chk("tmo_rdata", rd, 32'hdeadbeef);
        chk("tmo_first_held", {30'h0, err_cause}, 32'h1);
        chk("tmo_count", {24'h0, err_count}, 32'h2);

        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        chk("clr_valid", {31'h0, err_valid}, 32'h0);
        chk("clr_count", {24'h0, err_count}, 32'h0);

        do_access(32'hff000000, 4'h0, 32'h0, 0, 1'b0, 1'b1, lat, rd);
        chk("clr_err_count", {24'h0, err_count}, 32'h1);
        chk("clr_err_addr", err_addr, 32'hff000000);

        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        do_access(32'h04000000, 4'h0, 32'h0, 0, 1'b0, 1'b0, lat, rd);
        chk("tmo1_cause", {30'h0, err_cause}, 32'h2);
        chk("tmo1_addr", err_addr, 32'h04000000);

        for (int i = 0; i < 300; i++) do_access(32'h80000000 + i, 4'h0, 32'h0, 0, 1'b0, 1'b0, lat, rd);
        chk("sat_count", {24'h0, err_count}, 32'hff);

        do_access(32'h04000000, 4'h0, 32'h0, 2, 1'b0, 1'b0, lat, rd);
        chk("abort_cs", {24'h0, core_cs}, 32'h0);
        chk("abort_ready", {31'h0, cpu_ready}, 32'h0);
        do_access(32'h3f000020, 4'h0, 32'h0, 0, 1'b0, 1'b0, lat, rd);
        chk("post_rst_latency", lat, 32'd2);
        chk("post_rst_data", rd, 32'h12345678);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
